// File: rtl/instr_fetch_if.sv
// instr_fetch_if: memory read port, decode handshake and redirect of the fetch unit.
interface instr_fetch_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        input  redirect, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, instr_ready,
        output mem_req, mem_addr, instr_valid, instr, instr_pc
    );

    modport slave (
        output redirect, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, instr_ready,
        input  mem_req, mem_addr, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: fetch pointer, single-outstanding imem reads, and a small {pc, word} FIFO toward decode.
module instr_fetch #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic         clk,
    input logic         n_rst,
    instr_fetch_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DROP = 2'd3;

    logic [1:0]    state, state_nxt;
    logic [31:0]   fpc, issued_pc;
    logic [AW:0]   count, count_nxt;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [31:0]   word_mem [DEPTH];
    logic [31:0]   pc_mem [DEPTH];
    logic          push, pop, outstanding;

    assign bus.mem_req     = state == REQ;
    assign bus.mem_addr    = fpc;
    assign bus.instr_valid = count != '0;
    assign bus.instr       = word_mem[rd_ptr];
    assign bus.instr_pc    = pc_mem[rd_ptr];

    assign push      = state == WAIT && bus.mem_rvalid && !bus.redirect;
    assign pop       = bus.instr_valid && bus.instr_ready && !bus.redirect;
    assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
    // A response is still owed by memory and must be swallowed after a redirect.
    assign outstanding = (state == WAIT && !bus.mem_rvalid) || (state == REQ && bus.mem_gnt) ||
                         (state == DROP && !bus.mem_rvalid);

    assign state_nxt = bus.redirect   ? (outstanding ? DROP : REQ) :
                       state == IDLE  ? (count < FULL ? REQ : IDLE) :
                       state == REQ   ? (bus.mem_gnt ? WAIT : REQ) :
                       state == WAIT  ? (bus.mem_rvalid ? (count_nxt < FULL ? REQ : IDLE) : WAIT) :
                                        (bus.mem_rvalid ? REQ : DROP);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            fpc       <= RESET_PC;
            issued_pc <= RESET_PC;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                word_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else begin
            state <= state_nxt;
            if (bus.redirect) begin
                fpc    <= bus.redirect_pc & ~32'h3;
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (state == REQ && bus.mem_gnt) begin
                    issued_pc <= fpc;
                    fpc       <= fpc + 32'd4;
                end
                if (push) begin
                    word_mem[wr_ptr] <= bus.mem_rdata;
                    pc_mem[wr_ptr]   <= issued_pc;
                    wr_ptr           <= wr_ptr + 1'b1;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count_nxt;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of fetch, backpressure, redirect, address wrap and mid-transaction reset.
module tb_instr_fetch;
    logic clk = 0, n_rst = 0, n_rst1 = 0;
    always #5 clk = ~clk;

    instr_fetch_if a();
    instr_fetch_if b();

    instr_fetch dut0 (.clk(clk), .n_rst(n_rst), .bus(a.master));
    instr_fetch #(.RESET_PC(32'hFFFFFFFC)) dut1 (.clk(clk), .n_rst(n_rst1), .bus(b.master));

    int n_chk = 0, n_fail = 0;
    int lat = 1, timer = 0, gnt_cnt = 0;
    logic gnt_en = 0;
    logic [31:0] paddr;
    logic [31:0] gnt_addr [16];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(logic [31:0] addr);
        return addr == 32'h0 ? 32'h02328020 : addr == 32'h4 ? 32'h08000101 : {16'hA5A5, addr[15:0]};
    endfunction

    // Memory model for dut0: immediate grant, data after lat cycles.
    assign a.mem_gnt = a.mem_req & gnt_en;
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            timer <= 0;
            gnt_cnt <= 0;
            a.mem_rvalid <= 0;
            a.mem_rdata <= 0;
        end else begin
            a.mem_rvalid <= 0;
            if (a.mem_req && a.mem_gnt) begin
                if (gnt_cnt < 16) gnt_addr[gnt_cnt] <= a.mem_addr;
                gnt_cnt <= gnt_cnt + 1;
                paddr <= a.mem_addr;
                if (lat == 1) begin
                    a.mem_rvalid <= 1;
                    a.mem_rdata <= mem_word(a.mem_addr);
                end else timer <= lat - 1;
            end else if (timer > 0) begin
                timer <= timer - 1;
                if (timer == 1) begin
                    a.mem_rvalid <= 1;
                    a.mem_rdata <= mem_word(paddr);
                end
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset0;
        n_rst = 0;
        cyc(2);
        n_rst = 1;
    endtask

    task automatic wait_instr(string tag, logic [31:0] pc, int bound);
        bit seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            seen = a.instr_valid;
        end
        check({tag, " valid"}, {31'b0, a.instr_valid}, 32'd1);
        if (seen) begin
            check({tag, " pc"}, a.instr_pc, pc);
            check({tag, " instr"}, a.instr, mem_word(pc));
        end
    endtask

    initial begin
        a.redirect = 0; a.redirect_pc = 0; a.instr_ready = 0;
        b.redirect = 0; b.redirect_pc = 0; b.instr_ready = 0;
        b.mem_gnt = 0; b.mem_rvalid = 0; b.mem_rdata = 0;

        // Reset values, then first request
        cyc(2);
        check("rst mem_req", {31'b0, a.mem_req}, 32'd0);
        check("rst instr_valid", {31'b0, a.instr_valid}, 32'd0);
        check("rst mem_addr", a.mem_addr, 32'h0);
        check("rst instr", a.instr, 32'h0);
        check("rst instr_pc", a.instr_pc, 32'h0);
        n_rst = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (a.mem_req) break;
        end
        check("first req", {31'b0, a.mem_req}, 32'd1);
        check("first addr", a.mem_addr, 32'h0);

        // Sequential fetch at full rate
        reset0;
        gnt_en = 1; lat = 1; a.instr_ready = 1;
        wait_instr("seq0", 32'h0, 4);
        wait_instr("seq4", 32'h4, 2);
        wait_instr("seq8", 32'h8, 2);

        // Backpressure fills the FIFO and stops requesting
        a.instr_ready = 0;
        reset0;
        cyc(10);
        check("bp gnt count", gnt_cnt, 32'd2);
        check("bp gnt0 addr", gnt_addr[0], 32'h0);
        check("bp gnt1 addr", gnt_addr[1], 32'h4);
        check("bp mem_req", {31'b0, a.mem_req}, 32'd0);
        check("bp head pc", a.instr_pc, 32'h0);
        check("bp head instr", a.instr, 32'h02328020);
        a.instr_ready = 1;
        wait_instr("bp4", 32'h4, 1);
        wait_instr("bp8", 32'h8, 8);

        // Redirect while the read to 8 is in flight
        lat = 3;
        reset0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a.mem_req && a.mem_addr == 32'h8) break;
        end
        check("rd req8", a.mem_addr, 32'h8);
        cyc(1);
        a.redirect = 1; a.redirect_pc = 32'h00000405;
        cyc(1);
        a.redirect = 0;
        check("rd flush valid", {31'b0, a.instr_valid}, 32'd0);
        check("rd drop req", {31'b0, a.mem_req}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (a.mem_req) break;
        end
        check("rd req", {31'b0, a.mem_req}, 32'd1);
        check("rd addr", a.mem_addr, 32'h404);
        wait_instr("rd404", 32'h404, 8);

        // Redirect coinciding with push and pop
        lat = 1; a.instr_ready = 0;
        reset0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (a.instr_valid) break;
        end
        check("pp head pc", a.instr_pc, 32'h0);
        cyc(1);
        a.instr_ready = 1; a.redirect = 1; a.redirect_pc = 32'h1000;
        cyc(1);
        a.redirect = 0;
        check("pp valid", {31'b0, a.instr_valid}, 32'd0);
        check("pp req", {31'b0, a.mem_req}, 32'd1);
        check("pp addr", a.mem_addr, 32'h1000);
        wait_instr("pp1000", 32'h1000, 6);

        // Address wrap and reset mid-transaction on dut1
        cyc(2);
        check("wr rst addr", b.mem_addr, 32'hFFFFFFFC);
        check("wr rst req", {31'b0, b.mem_req}, 32'd0);
        n_rst1 = 1;
        cyc(1);
        check("wr req0", {31'b0, b.mem_req}, 32'd1);
        check("wr addr0", b.mem_addr, 32'hFFFFFFFC);
        b.mem_gnt = 1;
        cyc(1);
        b.mem_gnt = 0; b.mem_rvalid = 1; b.mem_rdata = 32'h11111111;
        cyc(1);
        b.mem_rvalid = 0;
        check("wr addr1", b.mem_addr, 32'h0);
        check("wr valid", {31'b0, b.instr_valid}, 32'd1);
        check("wr pc", b.instr_pc, 32'hFFFFFFFC);
        check("wr instr", b.instr, 32'h11111111);
        b.mem_gnt = 1;
        cyc(1);
        b.mem_gnt = 0;
        n_rst1 = 0;
        #1;
        check("mr req", {31'b0, b.mem_req}, 32'd0);
        check("mr valid", {31'b0, b.instr_valid}, 32'd0);
        check("mr addr", b.mem_addr, 32'hFFFFFFFC);
        check("mr instr", b.instr, 32'h0);
        check("mr pc", b.instr_pc, 32'h0);
        @(negedge clk);
        n_rst1 = 1; b.mem_rvalid = 1; b.mem_rdata = 32'hDEADBEEF;
        cyc(2);
        b.mem_rvalid = 0;
        cyc(2);
        check("stale valid", {31'b0, b.instr_valid}, 32'd0);
        check("stale req", {31'b0, b.mem_req}, 32'd1);
        check("stale addr", b.mem_addr, 32'hFFFFFFFC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
